// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button debounce block: FSM encoding and
// the board-level default qualification time.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // 20 ms at the 50 MHz board clock
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous pin inputs; both flops reset
// to RESET_VAL so the synchronized level is known immediately after reset.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic synced
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta   <= RESET_VAL;
      synced <= RESET_VAL;
    end else begin
      meta   <= pin;
      synced <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioning: synchronize the raw pin, qualify each change for
// DEBOUNCE_CYCLES cycles, then publish a clean level with press/release strobes.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, press_nxt, release_nxt;
  logic             key_sync, key_n;

  // Preset to the released pin level so leaving reset never looks like a press
  sync_2ff #(
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pin    (key_in),
    .synced (key_sync)
  );

  assign key_n = key_sync ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
    end
  end

  // cnt holds the length of the current run of samples opposing key_level
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = key_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (key_n) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!key_n) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = PRESSED;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!key_n) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (key_n) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt   = IDLE;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  assign busy = (state == PRESS_WAIT) || (state == RELEASE_WAIT);

endmodule
